// File: rtl/rf_pkg.sv
// Shared defaults and the dump sequencer state encoding for the register file.
package rf_pkg;

  localparam int unsigned RF_DW = 32;
  localparam int unsigned RF_AW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/rf_dump_seq.sv
// Dump sequencer: walks every register index once, one beat per accepted
// valid/ready handshake, then pulses dump_done for a single cycle.
module rf_dump_seq
  import rf_pkg::*;
#(
  parameter int unsigned DW = RF_DW,
  parameter int unsigned AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump_req,
  input  logic          dump_ready,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] rd_addr,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_idx,
  output logic [DW-1:0] dump_data,
  output logic          dump_done
);

  localparam logic [AW-1:0] LAST_IDX = '1;

  dump_state_e   state;
  logic [AW-1:0] idx;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;

  // Sequencer state, beat index and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_req) begin
            state   <= RUN;
            idx     <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (valid_q && dump_ready) begin
            if (idx == LAST_IDX) begin
              state   <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx <= idx + AW'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Beat data is the live array contents at the current index, so a write
  // landing on that register shows up while the beat is held.
  assign rd_addr    = idx;
  assign dump_data  = rd_data;
  assign dump_idx   = idx;
  assign dump_valid = valid_q;
  assign dump_busy  = busy_q;
  assign dump_done  = done_q;

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file: two bypassed combinational read ports, two
// prioritised write ports, and a handshake dump port for debug/trace.
module rf_mp
  import rf_pkg::*;
#(
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned AW       = RF_AW,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  input  logic          dump_req,
  output logic          dump_busy,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_idx,
  output logic [DW-1:0] dump_data,
  output logic          dump_done
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] rf [DEPTH];
  logic          wr_ok0;
  logic          wr_ok1;
  logic [AW-1:0] seq_addr;
  logic [DW-1:0] seq_data;

  // Writes to the hardwired zero register are dropped.
  assign wr_ok0 = we0 && !(ZERO_REG && (wa0 == '0));
  assign wr_ok1 = we1 && !(ZERO_REG && (wa1 == '0));

  // Storage; port 1 is applied last so it wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (wr_ok0) begin
        rf[wa0] <= wd0;
      end
      if (wr_ok1) begin
        rf[wa1] <= wd1;
      end
    end
  end

  // Read port 1: zero register, then port 1 bypass, then port 0 bypass, then array.
  always_comb begin
    RD1 = rf[A1];
    if (we0 && (wa0 == A1)) begin
      RD1 = wd0;
    end
    if (we1 && (wa1 == A1)) begin
      RD1 = wd1;
    end
    if (ZERO_REG && (A1 == '0)) begin
      RD1 = '0;
    end
  end

  // Read port 2: same selection order as port 1.
  always_comb begin
    RD2 = rf[A2];
    if (we0 && (wa0 == A2)) begin
      RD2 = wd0;
    end
    if (we1 && (wa1 == A2)) begin
      RD2 = wd1;
    end
    if (ZERO_REG && (A2 == '0)) begin
      RD2 = '0;
    end
  end

  // Third, unbypassed read port feeding the dump sequencer.
  assign seq_data = rf[seq_addr];

  rf_dump_seq #(
    .DW(DW),
    .AW(AW)
  ) u_dump_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .dump_req  (dump_req),
    .dump_ready(dump_ready),
    .rd_data   (seq_data),
    .rd_addr   (seq_addr),
    .dump_busy (dump_busy),
    .dump_valid(dump_valid),
    .dump_idx  (dump_idx),
    .dump_data (dump_data),
    .dump_done (dump_done)
  );

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp: one ZERO_REG=1 and one ZERO_REG=0 instance
// share all inputs and are compared against array models of the register file.
module tb_rf_mp;

  logic        clk;
  logic        rst_n;
  logic [4:0]  A1, A2;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        dump_req, dump_ready;

  logic [31:0] rd1_z, rd2_z, rd1_n, rd2_n;
  logic        busy_z, valid_z, done_z, busy_n, valid_n, done_n;
  logic [4:0]  idx_z, idx_n;
  logic [31:0] data_z, data_n;

  logic [31:0] mz [32];
  logic [31:0] mn [32];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;

  rf_mp #(.DW(32), .AW(5), .ZERO_REG(1'b1)) u_z (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .RD1(rd1_z), .RD2(rd2_z),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .dump_req(dump_req), .dump_busy(busy_z), .dump_valid(valid_z),
    .dump_ready(dump_ready), .dump_idx(idx_z), .dump_data(data_z), .dump_done(done_z)
  );

  rf_mp #(.DW(32), .AW(5), .ZERO_REG(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .RD1(rd1_n), .RD2(rd2_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .dump_req(dump_req), .dump_busy(busy_n), .dump_valid(valid_n),
    .dump_ready(dump_ready), .dump_idx(idx_n), .dump_data(data_n), .dump_done(done_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected read value from the architectural rules: zero reg, newest write, stored value.
  function automatic logic [31:0] exp_rd(input bit zero, input logic [4:0] a);
    if (zero && a == 5'd0) return 32'd0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return zero ? mz[a] : mn[a];
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      mz[i] = 32'd0;
      mn[i] = 32'd0;
    end
  endtask

  // Apply this cycle's writes to the models; port 1 applied last.
  task automatic commit();
    if (we0) begin
      mn[wa0] = wd0;
      if (wa0 != 5'd0) mz[wa0] = wd0;
    end
    if (we1) begin
      mn[wa1] = wd1;
      if (wa1 != 5'd0) mz[wa1] = wd1;
    end
  endtask

  task automatic check_reads();
    check("rd1_z", rd1_z, exp_rd(1'b1, A1));
    check("rd2_z", rd2_z, exp_rd(1'b1, A2));
    check("rd1_n", rd1_n, exp_rd(1'b0, A1));
    check("rd2_n", rd2_n, exp_rd(1'b0, A2));
  endtask

  // One clock: check combinational reads mid-low-phase, then clock the writes.
  task automatic step();
    #1;
    check_reads();
    @(posedge clk);
    commit();
    @(negedge clk);
  endtask

  task automatic rand_writes();
    we0 = 1'($urandom_range(0, 1));
    we1 = 1'($urandom_range(0, 1));
    wa0 = 5'($urandom_range(0, 31));
    wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
    wd0 = $urandom();
    wd1 = $urandom();
  endtask

  // Run one dump; rnd adds random ready/writes/stray requests, abort_at >= 0
  // asserts reset when that many beats have been accepted, kx4 checks data == idx*4.
  task automatic do_dump(input bit rnd, input int abort_at, input bit kx4);
    int  beats = 0;
    int  cyc   = 0;
    int  dones = 0;
    int  phase = 0;
    bit  fin   = 1'b0;
    we0 = 1'b0; we1 = 1'b0; dump_ready = 1'b0; dump_req = 1'b1;
    #1;
    check("busy_before_req", 32'(busy_z), 32'd0);
    @(posedge clk);
    @(negedge clk);
    dump_req = 1'b0;
    while (!fin && cyc < 500) begin
      cyc++;
      if (phase == 0 && abort_at >= 0 && beats == abort_at) begin
        check("abort_idx", 32'(idx_z), 32'(abort_at));
        dump_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_valid_z", 32'(valid_z), 32'd0);
        check("abort_busy_z", 32'(busy_z), 32'd0);
        check("abort_valid_n", 32'(valid_n), 32'd0);
        check("abort_busy_n", 32'(busy_n), 32'd0);
        check("abort_idx_z", 32'(idx_z), 32'd0);
        clear_models();
        repeat (2) begin
          @(posedge clk);
          #1;
          check("abort_no_done", 32'(done_z | done_n), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1'b1;
      end else begin
        if (rnd) begin
          dump_ready = 1'($urandom_range(0, 1));
          rand_writes();
          dump_req = (phase == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end else begin
          dump_ready = (cyc % 2) == 1;
          we0 = 1'b0; we1 = 1'b0; dump_req = 1'b0;
        end
        #1;
        case (phase)
          0: begin
            check("run_valid", 32'(valid_z & valid_n), 32'd1);
            check("run_busy", 32'(busy_z & busy_n), 32'd1);
            check("run_done", 32'(done_z | done_n), 32'd0);
            check("run_idx_z", 32'(idx_z), 32'(beats));
            check("run_idx_n", 32'(idx_n), 32'(beats));
            check("run_data_z", data_z, mz[5'(beats)]);
            check("run_data_n", data_n, mn[5'(beats)]);
            if (kx4) check("run_data_kx4", data_z, 32'(beats * 4));
          end
          1: begin
            dones++;
            check("done_valid", 32'(valid_z | valid_n), 32'd0);
            check("done_busy", 32'(busy_z & busy_n), 32'd1);
            check("done_pulse", 32'(done_z & done_n), 32'd1);
          end
          default: begin
            check("idle_busy", 32'(busy_z | busy_n), 32'd0);
            check("idle_done", 32'(done_z | done_n), 32'd0);
            check("idle_valid", 32'(valid_z | valid_n), 32'd0);
            fin = 1'b1;
          end
        endcase
        @(posedge clk);
        commit();
        if (phase == 0 && dump_ready) begin
          beats++;
          if (beats == 32) phase = 1;
        end else if (phase == 1) begin
          phase = 2;
        end
        @(negedge clk);
      end
    end
    if (!fin) check("dump_timeout", 32'd0, 32'd1);
    if (abort_at < 0) begin
      check("done_count", 32'(dones), 32'd1);
      check("beat_count", 32'(beats), 32'd32);
    end
    we0 = 1'b0; we1 = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    A1 = 5'd3; A2 = 5'd31;
    we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    dump_req = 1'b0; dump_ready = 1'b0;
    clear_models();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_rd1", rd1_z, 32'd0);
    check("rst_rd2", rd2_z, 32'd0);
    check("rst_valid", 32'(valid_z | valid_n), 32'd0);
    check("rst_busy", 32'(busy_z | busy_n), 32'd0);
    check("rst_done", 32'(done_z | done_n), 32'd0);
    check("rst_idx", 32'(idx_z), 32'd0);
    @(negedge clk);

    // Same-cycle bypass of port 0, then the stored value.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; A1 = 5'd5; A2 = 5'd3;
    #1;
    check("bypass_rd1", rd1_z, 32'hDEADBEEF);
    step();
    we0 = 1'b0;
    #1;
    check("stored_rd1", rd1_z, 32'hDEADBEEF);
    step();

    // Write collision: port 1 wins in the bypass and in storage.
    we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'h11; wd1 = 32'h22; A1 = 5'd7;
    #1;
    check("coll_bypass", rd1_z, 32'h22);
    step();
    we0 = 1'b0; we1 = 1'b0;
    #1;
    check("coll_stored", rd1_z, 32'h22);
    step();

    // Zero register behaviour on both instances.
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; A1 = 5'd0; A2 = 5'd0;
    #1;
    check("zero_bypass_z", rd1_z, 32'd0);
    check("zero_bypass_n", rd1_n, 32'hFFFFFFFF);
    step();
    we1 = 1'b0;
    #1;
    check("zero_stored_z", rd2_z, 32'd0);
    check("zero_stored_n", rd2_n, 32'hFFFFFFFF);
    step();

    // Random traffic against the model.
    repeat (300) begin
      rand_writes();
      A1 = ($urandom_range(0, 1) == 0) ? wa0 : 5'($urandom_range(0, 31));
      A2 = ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom_range(0, 31));
      step();
    end

    // Mid-test reset clears everything.
    we0 = 1'b0; we1 = 1'b0;
    rst_n = 1'b0;
    clear_models();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #1;
      check("midrst_rd1_n", rd1_n, 32'd0);
      step();
    end

    // Preload rf[k] = k*4 two registers per cycle, then dump with toggling ready.
    for (int k = 0; k < 16; k++) begin
      we0 = 1'b1; wa0 = 5'(2 * k);     wd0 = 32'(8 * k);
      we1 = 1'b1; wa1 = 5'(2 * k + 1); wd1 = 32'(8 * k + 4);
      A1 = wa0; A2 = wa1;
      step();
    end
    we0 = 1'b0; we1 = 1'b0;
    do_dump(1'b0, -1, 1'b1);

    // Reset at beat 10, then a fresh dump restarts from index 0.
    do_dump(1'b0, 10, 1'b0);
    do_dump(1'b0, -1, 1'b0);

    // Random contents, then a dump with random ready, live writes and stray requests.
    repeat (100) begin
      rand_writes();
      A1 = 5'($urandom_range(0, 31));
      A2 = 5'($urandom_range(0, 31));
      step();
    end
    do_dump(1'b1, -1, 1'b0);
    do_dump(1'b1, -1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rf_mp.md
Name: rf_mp

Overview:
- Parametrised multi-port general-purpose register file for the pipelined CPU.
- Provides two combinational read ports with same-cycle write-through bypass, and two synchronous write ports with fixed priority.
- Includes a handshake-driven dump sequencer that streams every register out, one per accepted beat, for debug and trace capture.
- Sits between decode (reads) and writeback (writes); the dump port feeds the debug/trace unit.

Parameters:
- DW, 32, data width of each register.
- AW, 5, address width; depth is 2**AW.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes; when 0 it is an ordinary register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- A1  in  AW  read port 1 address.
- A2  in  AW  read port 2 address.
- RD1  out  DW  read port 1 data.
- RD2  out  DW  read port 2 data.
- we0  in  1  write port 0 enable.
- wa0  in  AW  write port 0 address.
- wd0  in  DW  write port 0 data.
- we1  in  1  write port 1 enable; port 1 has priority over port 0.
- wa1  in  AW  write port 1 address.
- wd1  in  DW  write port 1 data.
- dump_req  in  1  start a dump; sampled only in IDLE.
- dump_busy  out  1  high while the sequencer is not IDLE.
- dump_valid  out  1  dump beat available.
- dump_ready  in  1  consumer accepts the beat.
- dump_idx  out  AW  register index of the current beat.
- dump_data  out  DW  register contents of the current beat.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers cleared to 0;
  - sequencer forced to IDLE;
  - dump_valid, dump_busy and dump_done = 0; dump_idx = 0.
  - RD1/RD2 then read 0 unless bypassed.
- Writes, rising edge:
  - if we0, rf[wa0] <= wd0; if we1, rf[wa1] <= wd1.
  - If both are enabled with wa0 == wa1, wd1 is stored.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads: combinational, zero latency. RDn is selected in this order:
  1. 0 if ZERO_REG and An == 0;
  2. wd1 if we1 and wa1 == An;
  3. wd0 if we0 and wa0 == An;
  4. rf[An].
  - The bypass makes a value written this cycle visible to a reader in the same cycle.
- Dump sequencer states:
  - IDLE: dump_req -> RUN, idx <= 0.
  - RUN: dump_valid = 1, dump_data = rf[idx] (live array value, no bypass).
    - On dump_valid & dump_ready with idx == 2**AW-1 -> DONE.
    - On dump_valid & dump_ready otherwise -> idx <= idx+1.
    - dump_idx and dump_data hold stable while dump_ready is low, except that dump_data tracks a write landing on rf[idx].
  - DONE: dump_done = 1 for exactly one cycle -> IDLE.
  - dump_busy = (state != IDLE).
- Boundary conditions:
  - dump_req while busy is ignored; no queueing.
  - Register writes continue normally during a dump. An index already emitted is not re-sent.
  - Reset during RUN aborts immediately with no dump_done pulse.
  - dump_idx wraps nowhere: the sequencer stops at 2**AW-1.
  - Register 0 is emitted as 0 when ZERO_REG=1.
- No simulation $display inside the block; trace goes through the dump port only.

Decomposition:
- Package rf_pkg: default DW and AW, and the sequencer state enum {IDLE, RUN, DONE}.
- One natural sub-module: rf_dump_seq, holding the FSM, index counter and handshake. It takes its read data from an internal third array read port.
- Storage, write priority and bypass muxes stay in the top level.

Test Plan:
- Reset then read: deassert rst_n with A1=3, A2=31 -> RD1=0, RD2=0. Assert rst_n mid-test after writes -> all reads return 0.
- Bypass: we0=1, wa0=5, wd0=0xDEADBEEF, A1=5 in the same cycle -> RD1=0xDEADBEEF before the edge, and rf[5] holds it after the edge.
- Write collision: we0=1, we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> RD1 (A1=7) = 0x22 in that cycle and after the edge.
- Zero register: we1=1, wa1=0, wd1=0xFFFFFFFF -> RD1 (A1=0) = 0 in that cycle and after. With ZERO_REG=0 -> 0xFFFFFFFF.
- Dump with backpressure: preload rf[k]=k*4. Pulse dump_req and toggle dump_ready 1/0 -> 32 beats, idx 0..31, data 0,4,...,124, each held stable while not ready; dump_done pulses once; dump_busy falls the next cycle.
- Reset mid-dump: assert rst_n low at beat 10 -> dump_valid=0 and dump_busy=0 immediately, no dump_done; a following dump_req restarts at idx 0.
